// File: rtl/scpu_mem_pkg.sv
// Shared memory-subsystem definitions for the SCPU ROM path.
// Holds ROM geometry, the requester-port enum and the ROM window range check.
package scpu_mem_pkg;

    localparam int unsigned ROM_ADDR_W = 11;
    localparam int unsigned ROM_DATA_W = 32;
    localparam logic [31:0] ROM_BASE   = 32'h0000_0000;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LD = 1'b1
    } port_sel_e;

    // True when addr is word-aligned inside [base, base + 4*2**addr_w); offset wraps mod 2**32.
    function automatic logic rom_range_ok(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input int unsigned addr_w);
        logic [31:0] off;
        logic [32:0] lim;
        off = addr - base;
        lim = 33'(1) << (addr_w + 32'd2);
        return (off[1:0] == 2'b00) && (33'(off) < lim);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a last-winner register.
// Ports: clk, rst (sync active-high), i_req_if / i_req_ld requests,
//        o_gnt_if_c / o_gnt_ld_c combinational one-hot grants.
module rr_arb2
    import scpu_mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req_if,
    input  logic i_req_ld,
    output logic o_gnt_if_c,
    output logic o_gnt_ld_c
);

    port_sel_e r_last;
    port_sel_e w_last_nxt;

    // Last-winner register; resets to LD so IF takes the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= PORT_LD;
        end else begin
            r_last <= w_last_nxt;
        end
    end

    // Grant logic; the last winner only moves on contended cycles.
    always_comb begin
        o_gnt_if_c = 1'b0;
        o_gnt_ld_c = 1'b0;
        w_last_nxt = r_last;
        if (i_req_if && i_req_ld) begin
            if (r_last == PORT_LD) begin
                o_gnt_if_c = 1'b1;
                w_last_nxt = PORT_IF;
            end else begin
                o_gnt_ld_c = 1'b1;
                w_last_nxt = PORT_LD;
            end
        end else begin
            o_gnt_if_c = i_req_if;
            o_gnt_ld_c = i_req_ld;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one combinational-read instruction ROM between the IF and LD ports.
// Ports: clk, rst (sync active-high);
//        if_req/if_addr -> if_gnt (comb), if_rvalid/if_rdata/if_err (registered);
//        ld_req/ld_addr -> ld_gnt (comb), ld_rvalid/ld_rdata/ld_err (registered);
//        rom_addr (comb word address) / rom_data (comb read data).
module rom_port_arbiter
    import scpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = ROM_ADDR_W,
    parameter int unsigned DATA_W   = ROM_DATA_W,
    parameter logic [31:0] ROM_BASE = scpu_mem_pkg::ROM_BASE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              ld_req,
    input  logic [31:0]       ld_addr,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    localparam int unsigned STREAK_W   = 4;
    localparam logic [STREAK_W-1:0] STREAK_MAX = 4'd15;

    logic              w_if_gnt;
    logic              w_ld_gnt;
    logic [31:0]       w_sel_addr;
    logic [31:0]       w_off;
    logic              w_ok;
    logic [DATA_W-1:0] w_rdata;

    logic              r_if_rvalid;
    logic              r_if_err;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_ld_rvalid;
    logic              r_ld_err;
    logic [DATA_W-1:0] r_ld_rdata;

    logic [STREAK_W-1:0] r_streak;
    logic [STREAK_W-1:0] w_streak_nxt;
    port_sel_e           r_denied;
    port_sel_e           w_denied_nxt;
    logic                w_if_denied;
    logic                w_ld_denied;

    rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .i_req_if   (if_req),
        .i_req_ld   (ld_req),
        .o_gnt_if_c (w_if_gnt),
        .o_gnt_ld_c (w_ld_gnt)
    );

    // Address mapping for the winner; rom_addr parks at 0 when idle.
    always_comb begin
        w_sel_addr = w_ld_gnt ? ld_addr : if_addr;
        w_off      = w_sel_addr - ROM_BASE;
        w_ok       = rom_range_ok(w_sel_addr, ROM_BASE, ADDR_W);
        rom_addr   = (w_if_gnt || w_ld_gnt) ? ADDR_W'(w_off >> 2) : '0;
        w_rdata    = w_ok ? rom_data : '0;
    end

    // Response registers; rdata holds its last value when the port is not granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_rvalid <= 1'b0;
            r_if_err    <= 1'b0;
            r_if_rdata  <= '0;
            r_ld_rvalid <= 1'b0;
            r_ld_err    <= 1'b0;
            r_ld_rdata  <= '0;
        end else begin
            r_if_rvalid <= w_if_gnt;
            r_if_err    <= w_if_gnt & ~w_ok;
            r_ld_rvalid <= w_ld_gnt;
            r_ld_err    <= w_ld_gnt & ~w_ok;
            if (w_if_gnt) r_if_rdata <= w_rdata;
            if (w_ld_gnt) r_ld_rdata <= w_rdata;
        end
    end

    // Starvation diagnostic: consecutive denials of the same port, saturating.
    always_comb begin
        w_streak_nxt = r_streak;
        w_denied_nxt = r_denied;
        w_if_denied  = if_req & ~w_if_gnt;
        w_ld_denied  = ld_req & ~w_ld_gnt;
        if (w_if_denied || w_ld_denied) begin
            w_denied_nxt = w_ld_denied ? PORT_LD : PORT_IF;
            if ((w_denied_nxt == r_denied) && (r_streak != '0)) begin
                w_streak_nxt = (r_streak == STREAK_MAX) ? STREAK_MAX : r_streak + 4'd1;
            end else begin
                w_streak_nxt = 4'd1;
            end
        end else if (((r_denied == PORT_IF) && w_if_gnt) ||
                     ((r_denied == PORT_LD) && w_ld_gnt)) begin
            w_streak_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak <= '0;
            r_denied <= PORT_IF;
        end else begin
            r_streak <= w_streak_nxt;
            r_denied <= w_denied_nxt;
        end
    end

    assign if_gnt    = w_if_gnt;
    assign ld_gnt    = w_ld_gnt;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign if_err    = r_if_err;
    assign ld_rvalid = r_ld_rvalid;
    assign ld_rdata  = r_ld_rdata;
    assign ld_err    = r_ld_err;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever a response window is due.
module tb_rom_port_arbiter;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 32;
    localparam int G_NONE = 0;
    localparam int G_IF   = 1;
    localparam int G_LD   = 2;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0, ld_req = 1'b0;
    logic [31:0]   if_addr = '0, ld_addr = '0;
    logic          if_gnt, ld_gnt, if_rvalid, ld_rvalid, if_err, ld_err;
    logic [DW-1:0] if_rdata, ld_rdata, rom_data;
    logic [AW-1:0] rom_addr;

    logic          hb_if_req = 1'b0;
    logic [31:0]   hb_if_addr = '0;
    logic          hb_if_gnt, hb_ld_gnt, hb_if_rvalid, hb_ld_rvalid, hb_if_err, hb_ld_err;
    logic [DW-1:0] hb_if_rdata, hb_ld_rdata, hb_rom_data;
    logic [AW-1:0] hb_rom_addr;

    logic [31:0] rom [2048];
    rsp_t        q [4][$];
    logic [31:0] last_rd [4];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic        rst_at_edge = 1'b1;
    logic        mdl_last_ld;

    always #5 clk = ~clk;

    assign rom_data    = rom[rom_addr];
    assign hb_rom_data = rom[hb_rom_addr];

    rom_port_arbiter u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt),
        .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_err(ld_err),
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    rom_port_arbiter #(.ROM_BASE(32'h8000_0000)) u_dut_hb (
        .clk(clk), .rst(rst),
        .if_req(hb_if_req), .if_addr(hb_if_addr), .if_gnt(hb_if_gnt),
        .if_rvalid(hb_if_rvalid), .if_rdata(hb_if_rdata), .if_err(hb_if_err),
        .ld_req(1'b0), .ld_addr(32'h0), .ld_gnt(hb_ld_gnt),
        .ld_rvalid(hb_ld_rvalid), .ld_rdata(hb_ld_rdata), .ld_err(hb_ld_err),
        .rom_addr(hb_rom_addr), .rom_data(hb_rom_data)
    );

    always @(posedge clk) begin
        cyc++;
        rst_at_edge = rst;
    end

    // Compare one response port against the head of its expectation queue.
    task automatic check_port(input int p, input string nm, input logic rv,
                              input logic [31:0] rd, input logic er);
        logic exp_v;
        rsp_t h;
        if (rst_at_edge) last_rd[p] = '0;
        exp_v = (q[p].size() > 0) && (q[p][0].due == cyc);
        total++;
        if (rv !== exp_v) begin
            bad++;
            $display("FAIL %s_rvalid cyc=%0d got=%b exp=%b", nm, cyc, rv, exp_v);
        end
        if (exp_v) begin
            h = q[p].pop_front();
            total++;
            if (rd !== h.data || er !== h.err) begin
                bad++;
                $display("FAIL %s_resp cyc=%0d got=%h/%b exp=%h/%b", nm, cyc, rd, er, h.data, h.err);
            end
            last_rd[p] = h.data;
        end else begin
            total++;
            if (rd !== last_rd[p]) begin
                bad++;
                $display("FAIL %s_rdata_hold cyc=%0d got=%h exp=%h", nm, cyc, rd, last_rd[p]);
            end
        end
    endtask

    always @(negedge clk) begin
        check_port(0, "if", if_rvalid, if_rdata, if_err);
        check_port(1, "ld", ld_rvalid, ld_rdata, ld_err);
        check_port(2, "hb_if", hb_if_rvalid, hb_if_rdata, hb_if_err);
        check_port(3, "hb_ld", hb_ld_rvalid, hb_ld_rdata, hb_ld_err);
        total++;
        if (u_dut.r_streak > 4'd1) begin
            bad++;
            $display("FAIL streak cyc=%0d got=%0d exp<=1", cyc, u_dut.r_streak);
        end
    end

    // Drive one cycle on the main instance; check grant, queue the expected response.
    task automatic drive(input logic ir, input logic [31:0] ia, input logic lr,
                         input logic [31:0] la, input int eg,
                         input logic [31:0] ed, input logic ee);
        logic [1:0] got, expg;
        if_req = ir; if_addr = ia; ld_req = lr; ld_addr = la;
        #1;
        got  = {ld_gnt, if_gnt};
        expg = (eg == G_IF) ? 2'b01 : (eg == G_LD) ? 2'b10 : 2'b00;
        total++;
        if (got !== expg) begin
            bad++;
            $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, got, expg);
        end
        if (eg == G_NONE) begin
            total++;
            if (rom_addr !== '0) begin
                bad++;
                $display("FAIL idle_rom_addr cyc=%0d got=%h exp=0", cyc, rom_addr);
            end
        end
        if (eg == G_IF) q[0].push_back('{cyc + 1, ed, ee});
        if (eg == G_LD) q[1].push_back('{cyc + 1, ed, ee});
        @(posedge clk); #1;
    endtask

    task automatic drive_hb(input logic ir, input logic [31:0] ia,
                            input logic [31:0] ed, input logic ee);
        hb_if_req = ir; hb_if_addr = ia;
        #1;
        total++;
        if (hb_if_gnt !== ir) begin
            bad++;
            $display("FAIL hb_grant cyc=%0d got=%b exp=%b", cyc, hb_if_gnt, ir);
        end
        if (ir) q[2].push_back('{cyc + 1, ed, ee});
        @(posedge clk); #1;
    endtask

    task automatic reset_cycle(input logic ir, input logic lr);
        rst = 1'b1; if_req = ir; ld_req = lr;
        @(posedge clk); #1;
        rst = 1'b0; if_req = 1'b0; ld_req = 1'b0;
    endtask

    function automatic rsp_t model(input logic [31:0] a);
        logic [31:0] off;
        off = a;
        if (off[1:0] != 2'b00 || off >= 32'h2000) return '{0, 32'h0, 1'b1};
        return '{0, rom[off[12:2]], 1'b0};
    endfunction

    initial begin
        logic        ir, lr;
        logic [31:0] ia, la;
        int          eg;
        rsp_t        m;
        for (int i = 0; i < 2048; i++) rom[i] = 32'(i) + 32'h100;
        for (int i = 0; i < 4; i++) last_rd[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // IF-only stream
        drive(1, 32'h0, 0, 0, G_IF, 32'h100, 0);
        drive(1, 32'h4, 0, 0, G_IF, 32'h101, 0);
        drive(1, 32'h8, 0, 0, G_IF, 32'h102, 0);
        // Contention, alternating
        drive(1, 32'h10, 1, 32'h20, G_IF, 32'h104, 0);
        drive(1, 32'h10, 1, 32'h20, G_LD, 32'h108, 0);
        drive(1, 32'h10, 1, 32'h20, G_IF, 32'h104, 0);
        drive(1, 32'h10, 1, 32'h20, G_LD, 32'h108, 0);
        drive(0, 0, 0, 0, G_NONE, 0, 0);
        // Range and alignment
        drive(0, 0, 1, 32'h2000, G_LD, 32'h0, 1);
        drive(0, 0, 1, 32'h6,    G_LD, 32'h0, 1);
        drive(0, 0, 1, 32'h1FFC, G_LD, 32'h8FF, 0);
        drive(0, 0, 0, 0, G_NONE, 0, 0);
        drive(0, 0, 0, 0, G_NONE, 0, 0);
        // Non-zero ROM base
        drive_hb(1, 32'h7FFF_FFFC, 32'h0, 1);
        drive_hb(1, 32'h8000_0004, 32'h101, 0);
        drive_hb(1, 32'h8000_0000, 32'h100, 0);
        drive_hb(0, 0, 0, 0);
        // IF wins a contention, then reset: IF must win again afterwards
        drive(1, 32'hC, 1, 32'h1C, G_IF, 32'h103, 0);
        reset_cycle(1, 1);
        drive(0, 0, 0, 0, G_NONE, 0, 0);
        drive(1, 32'h14, 1, 32'h18, G_IF, 32'h105, 0);
        drive(1, 32'h14, 1, 32'h18, G_LD, 32'h106, 0);
        drive(0, 0, 0, 0, G_NONE, 0, 0);

        // Random sweep against a reference model
        reset_cycle(0, 0);
        mdl_last_ld = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ir = 1'($urandom_range(0, 1));
            lr = 1'($urandom_range(0, 1));
            ia = 32'($urandom_range(0, 32'h23FF));
            la = 32'($urandom_range(0, 32'h23FF));
            if (ir && lr) begin
                eg = mdl_last_ld ? G_IF : G_LD;
                mdl_last_ld = (eg == G_LD);
            end else if (ir) eg = G_IF;
            else if (lr) eg = G_LD;
            else eg = G_NONE;
            m = model((eg == G_LD) ? la : ia);
            drive(ir, ia, lr, la, eg, m.data, m.err);
        end
        drive(0, 0, 0, 0, G_NONE, 0, 0);
        drive(0, 0, 0, 0, G_NONE, 0, 0);

        for (int p = 0; p < 4; p++) begin
            total++;
            if (q[p].size() != 0) begin
                bad++;
                $display("FAIL leftover_q%0d got=%0d exp=0", p, q[p].size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
